rx_engine: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/rx_engine_if.sv | 29 ++
 rtl/rx_sync.sv | 23 ++
 rtl/rx_engine.sv | 126 ++++++++++++
 tb/tb_rx_engine.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame constants, result
// payload and the parity helper used by both the transmit and receive engines.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RECV  = 2'd2
  } rx_state_e;

  localparam int unsigned DATA_BITS_7       = 7;
  localparam int unsigned MAX_FRAME_SAMPLES = 10;

  // Result of one received frame as presented to the read side
  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_result_t;

  // Parity bit the transmitter would send: even sense when ohel=0, odd when 1
  function automatic logic par_calc(input logic [7:0] data, input logic eight,
                                    input logic ohel);
    logic p;
    p = eight ? ^data : ^data[DATA_BITS_7-1:0];
    return p ^ ohel;
  endfunction

endpackage

// File: rtl/rx_engine_if.sv
// Receive-engine bus: serial line, frame format controls and the
// processor-side read interface.
//   master : drives RX, K, eight, parity, OHEL, READ; observes results
//   slave  : the receive engine
interface rx_engine_if #(
  parameter int unsigned K_W = 19
);
  logic           RX;
  logic [K_W-1:0] K;
  logic           eight;
  logic           parity;
  logic           OHEL;
  logic           READ;
  logic [7:0]     UART_RDATA;
  logic           RXRDY;
  logic           PERR;
  logic           FERR;
  logic           OVF;

  modport master (
    output RX, K, eight, parity, OHEL, READ,
    input  UART_RDATA, RXRDY, PERR, FERR, OVF
  );

  modport slave (
    input  RX, K, eight, parity, OHEL, READ,
    output UART_RDATA, RXRDY, PERR, FERR, OVF
  );
endinterface

// File: rtl/rx_sync.sv
// Generic multi-flop synchronizer, resets to 1 (idle line level).
//   clk, rst_n : clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output
module rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: recovers start / 7-8 data / optional parity / stop
// frames from RX and presents byte plus PERR/FERR/OVF status.
//   clk, rst : clock, async active-low reset
//   bus      : rx_engine_if slave (line, format controls, read interface)
module rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned K_W         = 19,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  rx_engine_if.slave bus
);

  localparam int unsigned SW = MAX_FRAME_SAMPLES;

  logic rxs;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (bus.RX),
    .q_o  (rxs)
  );

  rx_state_e      state_q, state_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [SW-1:0]  shreg_q, shreg_d;
  rx_result_t     res_q, res_d;
  logic           rxrdy_q, rxrdy_d;
  logic           ovf_q, ovf_d;

  logic           hbtu, btu;
  logic [3:0]     n_samples;
  logic [SW:0]    frame;
  logic [8:0]     aligned;
  logic [7:0]     data;
  logic           pbit;

  assign hbtu      = (cnt_q == (bus.K >> 1));
  assign btu       = (cnt_q == bus.K);
  assign n_samples = 4'd8 + 4'(bus.eight) + 4'(bus.parity);

  // Shift register contents including the sample being taken this clock;
  // the newest n_samples occupy the top bits, so shift b0 down to bit 0.
  assign frame   = {rxs, shreg_q};
  assign aligned = 9'(frame >> (4'(SW + 1) - n_samples));
  assign data    = {bus.eight & aligned[7], aligned[6:0]};
  assign pbit    = bus.eight ? aligned[8] : aligned[7];

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + K_W'(1);
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    res_d    = res_q;
    rxrdy_d  = rxrdy_q & ~bus.READ;
    ovf_d    = ovf_q & ~bus.READ;
    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (hbtu) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d  = ST_RECV;
            bitcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RECV: begin
        if (btu) begin
          cnt_d    = '0;
          shreg_d  = frame[SW:1];
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == n_samples - 4'd1) begin
            state_d    = ST_IDLE;
            res_d.data = data;
            res_d.perr = bus.parity & (pbit != par_calc(data, bus.eight, bus.OHEL));
            res_d.ferr = ~rxs;
            rxrdy_d    = 1'b1;
            // A read on the completion clock consumes the old byte: no overrun
            ovf_d      = ~bus.READ & (ovf_q | rxrdy_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      res_q    <= '0;
      rxrdy_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      res_q    <= res_d;
      rxrdy_q  <= rxrdy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.UART_RDATA = res_q.data;
  assign bus.PERR       = res_q.perr;
  assign bus.FERR       = res_q.ferr;
  assign bus.RXRDY      = rxrdy_q;
  assign bus.OVF        = ovf_q;

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine with K=9 (10 clocks per bit).
module tb_rx_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   lat    = -1;

  always #5 clk = ~clk;

  rx_engine_if #(.K_W(19)) bus ();

  rx_engine #(.K_W(19), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_lat(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) passes++;
    else $error("FAIL %s: observed latency %0d expected %0d +/-1", tag, obs, exp);
  endtask

  // Sends start bit then n bits of 'bits' LSB first, 10 clocks each.
  // Records clocks from RX fall to RXRDY rise in lat; READ pulses on
  // clock number read_at (0 = none). Starts and ends at a negedge.
  task automatic send(input logic [9:0] bits, input int n, input int read_at);
    logic [9:0] sh;
    logic       prev;
    int         cyc;
    sh   = bits;
    prev = bus.RXRDY;
    cyc  = 0;
    lat  = -1;
    for (int b = 0; b <= n; b++) begin
      if (b == 0) bus.RX = 1'b0;
      else begin
        bus.RX = sh[0];
        sh     = sh >> 1;
      end
      repeat (10) begin
        bus.READ = (cyc + 1 == read_at);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.READ = 1'b0;
        if (!prev && bus.RXRDY && lat < 0) lat = cyc;
        prev = bus.RXRDY;
      end
    end
    bus.RX = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_pulse();
    bus.READ = 1'b1;
    @(negedge clk);
    bus.READ = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.RX     = 1'b1;
    bus.K      = 19'd9;
    bus.eight  = 1'b1;
    bus.parity = 1'b0;
    bus.OHEL   = 1'b0;
    bus.READ   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", 32'(bus.UART_RDATA), 32'h0);
    check("rst_rxrdy", 32'(bus.RXRDY), 32'h0);
    check("rst_status", 32'({bus.PERR, bus.FERR, bus.OVF}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 8N1, 0xA5
    send(10'h1A5, 9, 0);
    check("a5_rdata", 32'(bus.UART_RDATA), 32'hA5);
    check("a5_rxrdy", 32'(bus.RXRDY), 32'h1);
    check("a5_status", 32'({bus.PERR, bus.FERR, bus.OVF}), 32'h0);
    check_lat("a5_lat", lat, 98);
    read_pulse();
    check("a5_read_rxrdy", 32'(bus.RXRDY), 32'h0);

    // 7E1, 0x35 good parity then bad parity
    bus.eight  = 1'b0;
    bus.parity = 1'b1;
    bus.OHEL   = 1'b0;
    send(10'h135, 9, 0);
    check("p35_rdata", 32'(bus.UART_RDATA), 32'h35);
    check("p35_perr", 32'(bus.PERR), 32'h0);
    check_lat("p35_lat", lat, 98);
    read_pulse();
    send(10'h1B5, 9, 0);
    check("p35bad_perr", 32'(bus.PERR), 32'h1);
    check("p35bad_rxrdy", 32'(bus.RXRDY), 32'h1);
    check("p35bad_rdata", 32'(bus.UART_RDATA), 32'h35);
    check("p35bad_ovf", 32'(bus.OVF), 32'h0);
    read_pulse();

    // 8O1, 0xFF with stop bit 0, then a clean frame
    bus.eight = 1'b1;
    bus.OHEL  = 1'b1;
    send(10'h1FF, 10, 0);
    check("ff_rdata", 32'(bus.UART_RDATA), 32'hFF);
    check("ff_ferr", 32'(bus.FERR), 32'h1);
    check("ff_perr", 32'(bus.PERR), 32'h0);
    check_lat("ff_lat", lat, 108);
    repeat (10) @(negedge clk);
    check("ff_after_ovf", 32'(bus.OVF), 32'h0);
    read_pulse();
    send(10'h35A, 10, 0);
    check("5a_rdata", 32'(bus.UART_RDATA), 32'h5A);
    check("5a_status", 32'({bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}), 32'h8);
    read_pulse();

    // 3-clock glitch is rejected
    bus.parity = 1'b0;
    bus.OHEL   = 1'b0;
    bus.RX     = 1'b0;
    repeat (3) @(negedge clk);
    bus.RX = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_rxrdy", 32'(bus.RXRDY), 32'h0);
    check("glitch_rdata", 32'(bus.UART_RDATA), 32'h5A);

    // Back-to-back without READ -> overrun
    send(10'h111, 9, 0);
    send(10'h122, 9, 0);
    check("ovf_rdata", 32'(bus.UART_RDATA), 32'h22);
    check("ovf_ovf", 32'(bus.OVF), 32'h1);
    check("ovf_rxrdy", 32'(bus.RXRDY), 32'h1);
    read_pulse();
    check("ovf_clr", 32'({bus.RXRDY, bus.OVF}), 32'h0);

    // READ on the completion clock: completion wins, no overrun
    send(10'h111, 9, 0);
    send(10'h133, 9, 98);
    check("rd_done_rxrdy", 32'(bus.RXRDY), 32'h1);
    check("rd_done_ovf", 32'(bus.OVF), 32'h0);
    check("rd_done_rdata", 32'(bus.UART_RDATA), 32'h33);

    // Reset during the data bits of 0x5A
    bus.RX = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.RX = (i % 2 == 1);
      repeat (10) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("midrst_outputs", 32'({bus.UART_RDATA, bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}), 32'h0);
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_rxrdy", 32'(bus.RXRDY), 32'h0);
    send(10'h13C, 9, 0);
    check("3c_rdata", 32'(bus.UART_RDATA), 32'h3C);
    check("3c_status", 32'({bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}), 32'h8);
    check_lat("3c_lat", lat, 98);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
